// File: rtl/mii_tx_pkg.sv
// mii_tx_pkg: shared FSM states and framing constants for the MII transmit engine
package mii_tx_pkg;
   typedef enum logic [3:0] {
      IDLE, PTR_LAT, DRAIN, PREAMBLE, SFD, DATA, PAD, FCS, IFG
   } state_t;
   localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
   localparam logic [3:0]  SFD_NIB      = 4'hD;
   localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: combinational one-byte update of the reflected IEEE 802.3 CRC-32
module crc32_d8
   import mii_tx_pkg::*;
(
   input  logic [31:0] crc_i,
   input  logic [7:0]  data_i,
   output logic [31:0] crc_o
);
   // shift the byte in LSB first, folding the polynomial whenever a one drops out
   always_comb begin
      crc_o = crc_i ^ {24'h0, data_i};
      for (int i = 0; i < 8; i++) crc_o = crc_o[0] ? ((crc_o >> 1) ^ CRC_POLY) : (crc_o >> 1);
   end
endmodule

// File: rtl/mii_tx_frame_ctrl.sv
// mii_tx_frame_ctrl: descriptor-driven MII transmitter adding preamble, pad, FCS and inter-frame gap
module mii_tx_frame_ctrl
   import mii_tx_pkg::*;
#(
   parameter int MIN_LEN   = 60,
   parameter int MAX_LEN   = 1514,
   parameter int IFG_BYTES = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ptr_fifo_empty,
   output logic        ptr_fifo_rd,
   input  logic [15:0] ptr_fifo_dout,
   output logic        data_fifo_rd,
   input  logic [7:0]  data_fifo_dout,
   output logic [3:0]  MII_TXD,
   output logic        MII_TX_EN,
   output logic        MII_TX_ER,
   output logic [15:0] tx_frame_cnt,
   output logic [15:0] tx_drop_cnt
);
   localparam logic [11:0] MIN_L    = 12'(MIN_LEN);
   localparam logic [11:0] MAX_L    = 12'(MAX_LEN);
   localparam logic [11:0] IFG_LAST = 12'(2 * IFG_BYTES - 1);
   state_t      state_q, state_d;
   logic [11:0] len_q, len_d, cnt_q, cnt_d, ptr_len;
   logic        phase_q, phase_d, slot, unused_hi;
   logic [7:0]  byte_q, byte_d, cur_byte;
   logic [31:0] crc_q, crc_d, crc_nxt, fcs;
   logic [15:0] frame_q, frame_d, drop_q, drop_d;
   assign ptr_len   = ptr_fifo_dout[11:0];
   assign unused_hi = ^ptr_fifo_dout[15:12];
   assign slot      = state_q inside {DATA, PAD, FCS};
   assign fcs       = ~crc_q;
   // byte 0 reaches the FIFO output only one cycle after the SFD prefetch, so every data
   // byte's low nibble is taken straight from the FIFO and the byte is held for its high nibble
   assign cur_byte  = state_q == DATA ? data_fifo_dout : state_q == FCS ? 8'(fcs >> {cnt_q[1:0], 3'b000}) : 8'h00;
   crc32_d8 u_crc (.crc_i(crc_q), .data_i(cur_byte), .crc_o(crc_nxt));
   assign ptr_fifo_rd  = ~rst & (state_q == IDLE) & ~ptr_fifo_empty;
   assign data_fifo_rd = (state_q == SFD) | (state_q == DRAIN) | ((state_q == DATA) & ~phase_q & (cnt_q + 12'd1 < len_q));
   assign MII_TX_EN    = slot | (state_q == PREAMBLE) | (state_q == SFD);
   assign MII_TXD      = state_q == PREAMBLE ? PREAMBLE_NIB : state_q == SFD ? SFD_NIB : !slot ? 4'h0 : phase_q ? byte_q[7:4] : cur_byte[3:0];
   assign MII_TX_ER    = 1'b0;
   assign tx_frame_cnt = frame_q;
   assign tx_drop_cnt  = drop_q;
   // frame sequencing: descriptor fetch, drop/drain, preamble, two-cycle byte slots, gap
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      byte_d  = byte_q;
      crc_d   = crc_q;
      frame_d = frame_q;
      drop_d  = drop_q;
      case (state_q)
         IDLE: state_d = ptr_fifo_empty ? IDLE : PTR_LAT;
         PTR_LAT: begin
            len_d   = ptr_len;
            cnt_d   = '0;
            phase_d = 1'b0;
            crc_d   = CRC_INIT;
            drop_d  = ptr_len == '0 ? drop_q + 16'd1 : drop_q;
            state_d = ptr_len == '0 ? IDLE : ptr_len > MAX_L ? DRAIN : PREAMBLE;
         end
         DRAIN: begin
            cnt_d = cnt_q + 12'd1;
            if (cnt_q == len_q - 12'd1) begin
               drop_d  = drop_q + 16'd1;
               state_d = IDLE;
            end
         end
         PREAMBLE: begin
            cnt_d   = cnt_q == 12'd14 ? '0 : cnt_q + 12'd1;
            state_d = cnt_q == 12'd14 ? SFD : PREAMBLE;
         end
         SFD: state_d = DATA;
         DATA, PAD, FCS: begin
            phase_d = ~phase_q;
            if (!phase_q) begin
               byte_d = cur_byte;
               crc_d  = state_q == FCS ? crc_q : crc_nxt;
            end else begin
               cnt_d = cnt_q + 12'd1;
               if (state_q == DATA && cnt_q == len_q - 12'd1) begin
                  state_d = len_q < MIN_L ? PAD : FCS;
                  cnt_d   = len_q < MIN_L ? cnt_q + 12'd1 : '0;
               end
               if (state_q == PAD && cnt_q == MIN_L - 12'd1) begin
                  state_d = FCS;
                  cnt_d   = '0;
               end
               if (state_q == FCS && cnt_q == 12'd3) begin
                  state_d = IFG;
                  cnt_d   = '0;
                  frame_d = frame_q + 16'd1;
               end
            end
         end
         IFG: begin
            cnt_d   = cnt_q + 12'd1;
            state_d = cnt_q == IFG_LAST ? IDLE : IFG;
         end
         default: state_d = IDLE;
      endcase
   end
   // register update; reset abandons any frame in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         phase_q <= 1'b0;
         byte_q  <= '0;
         crc_q   <= CRC_INIT;
         frame_q <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         byte_q  <= byte_d;
         crc_q   <= crc_d;
         frame_q <= frame_d;
         drop_q  <= drop_d;
      end
   end
endmodule

// File: tb/tb_mii_tx_frame_ctrl.sv
// tb_mii_tx_frame_ctrl: directed frames against FIFO models with an independent CRC/frame builder
module tb_mii_tx_frame_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ptr_fifo_empty, ptr_fifo_rd, data_fifo_rd, MII_TX_EN, MII_TX_ER;
   logic [15:0] ptr_fifo_dout = '0;
   logic [7:0]  data_fifo_dout = '0;
   logic [3:0]  MII_TXD;
   logic [15:0] tx_frame_cnt, tx_drop_cnt;
   logic [31:0] cu_in, cu_out;
   logic [7:0]  cu_d;
   logic [15:0] pmem [64];
   logic [7:0]  dmem [4096];
   int pw = 0, pr = 0, dw = 0, dr = 0;
   logic [3:0]  nib [4096];
   int hi_run [64], lo_gap [64];
   int nn = 0, nruns = 0, cur_hi = 0, cur_lo = 0, n_pr = 0, n_dr = 0;
   logic en_prev = 1'b0;
   int n_vec = 0, n_err = 0;

   always #20 clk = ~clk;

   mii_tx_frame_ctrl dut (
      .clk(clk), .rst(rst),
      .ptr_fifo_empty(ptr_fifo_empty), .ptr_fifo_rd(ptr_fifo_rd), .ptr_fifo_dout(ptr_fifo_dout),
      .data_fifo_rd(data_fifo_rd), .data_fifo_dout(data_fifo_dout),
      .MII_TXD(MII_TXD), .MII_TX_EN(MII_TX_EN), .MII_TX_ER(MII_TX_ER),
      .tx_frame_cnt(tx_frame_cnt), .tx_drop_cnt(tx_drop_cnt)
   );

   crc32_d8 u_crc_unit (.crc_i(cu_in), .data_i(cu_d), .crc_o(cu_out));

   assign ptr_fifo_empty = (pr == pw);

   // FIFO models: output valid the cycle after a pop and held otherwise; reset flushes
   always @(posedge clk) begin
      if (rst) begin
         pr <= pw;
         dr <= dw;
      end else begin
         if (ptr_fifo_rd) begin
            ptr_fifo_dout <= pmem[pr];
            pr <= pr + 1;
         end
         if (data_fifo_rd) begin
            data_fifo_dout <= dmem[dr];
            dr <= dr + 1;
         end
      end
   end

   // MII monitor: captures nibbles, TX_EN run lengths and the gaps preceding them
   always @(negedge clk) begin
      if (ptr_fifo_rd) n_pr <= n_pr + 1;
      if (data_fifo_rd) n_dr <= n_dr + 1;
      if (MII_TX_EN) begin
         nib[nn] <= MII_TXD;
         nn <= nn + 1;
         if (!en_prev) lo_gap[nruns] <= cur_lo;
         cur_hi <= cur_hi + 1;
         cur_lo <= 0;
      end else begin
         if (en_prev) begin
            hi_run[nruns] <= cur_hi;
            nruns <= nruns + 1;
            cur_hi <= 0;
         end
         cur_lo <= cur_lo + 1;
      end
      en_prev <= MII_TX_EN;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_vec++;
      if (obs !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, req);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick;
      tick;
      rst = 1'b0;
      tick;
   endtask

   function automatic logic [7:0] pat(input int kind, input int i);
      logic [7:0] v = 8'(i);
      return kind == 0 ? v : kind == 1 ? v + 8'hA0 : kind == 2 ? v * 8'd7 + 8'd3 : kind == 3 ? 8'hFF - v : (v * 8'd13) ^ 8'h5A;
   endfunction

   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   // descriptor upper nibble carries junk that the DUT must ignore
   task automatic push_frame(input int len, input int kind);
      for (int i = 0; i < len; i++) dmem[dw + i] = pat(kind, i);
      dw = dw + len;
      pmem[pw] = {4'hA, 12'(len)};
      pw = pw + 1;
   endtask

   task automatic wait_runs(input string tag, input int target, input int budget);
      for (int c = 0; c < budget && nruns < target; c++) tick;
      chk({tag, " frames seen"}, nruns, target);
   endtask

   task automatic check_frame(input string tag, input int run, input int s_nib, input int len, input int kind);
      logic [3:0]  e [256];
      logic [31:0] c, fo;
      logic [7:0]  b;
      int n, bad, body;
      body = len < 60 ? 60 : len;
      for (int k = 0; k < 15; k++) e[k] = 4'h5;
      e[15] = 4'hD;
      n = 16;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < body; i++) begin
         b = i < len ? pat(kind, i) : 8'h00;
         c = crc_step(c, b);
         e[n] = b[3:0];
         e[n + 1] = b[7:4];
         n = n + 2;
      end
      c = ~c;
      for (int k = 0; k < 8; k++) e[n + k] = c[4*k +: 4];
      n = n + 8;
      chk({tag, " tx_en cycles"}, hi_run[run], 2 * (8 + body + 4));
      bad = 0;
      for (int k = 0; k < n; k++) if (nib[s_nib + k] !== e[k]) bad++;
      chk({tag, " bad nibbles"}, bad, 0);
      fo = '0;
      for (int k = 0; k < 8; k++) fo[4*k +: 4] = nib[s_nib + n - 8 + k];
      chk({tag, " fcs"}, fo, c);
   endtask

   task automatic run_single(input string tag, input int len, input int kind);
      int s_run, s_nib, s_pr, s_dr;
      do_reset;
      s_run = nruns; s_nib = nn; s_pr = n_pr; s_dr = n_dr;
      push_frame(len, kind);
      wait_runs(tag, s_run + 1, 1000);
      repeat (30) tick;
      check_frame(tag, s_run, s_nib, len, kind);
      chk({tag, " ptr pops"}, n_pr - s_pr, 1);
      chk({tag, " data pops"}, n_dr - s_dr, len);
      chk({tag, " frame cnt"}, tx_frame_cnt, 1);
      chk({tag, " drop cnt"}, tx_drop_cnt, 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int s_run, s_nib, s_pr, s_dr, busy;
      string s;
      repeat (3) tick;
      chk("reset tx_en", MII_TX_EN, 0);
      chk("reset txd", MII_TXD, 0);
      chk("reset tx_er", MII_TX_ER, 0);
      chk("reset ptr_rd", ptr_fifo_rd, 0);
      chk("reset data_rd", data_fifo_rd, 0);
      chk("reset frame cnt", tx_frame_cnt, 0);
      chk("reset drop cnt", tx_drop_cnt, 0);
      rst = 1'b0;
      run_single("len60", 60, 0);
      run_single("len20 padded", 20, 1);
      // back to back: 100-byte frame is 2*(8+100+4)=224 cycles, 64-byte is 2*(8+64+4)=152;
      // gap = 24 IFG cycles + IDLE pop + PTR_LAT
      do_reset;
      s_run = nruns; s_nib = nn; s_dr = n_dr;
      push_frame(100, 2);
      push_frame(64, 3);
      wait_runs("b2b", s_run + 2, 2000);
      repeat (30) tick;
      check_frame("b2b first", s_run, s_nib, 100, 2);
      check_frame("b2b second", s_run + 1, s_nib + 224, 64, 3);
      chk("b2b gap", lo_gap[s_run + 1], 26);
      chk("b2b data pops", n_dr - s_dr, 164);
      chk("b2b frame cnt", tx_frame_cnt, 2);
      // zero-length descriptor, oversized descriptor, then a good frame
      do_reset;
      s_run = nruns; s_nib = nn; s_pr = n_pr; s_dr = n_dr;
      pmem[pw] = 16'h5000;
      pw = pw + 1;
      repeat (10) tick;
      chk("len0 data pops", n_dr - s_dr, 0);
      chk("len0 drop cnt", tx_drop_cnt, 1);
      push_frame(1600, 2);
      push_frame(60, 0);
      wait_runs("drop", s_run + 1, 6000);
      repeat (30) tick;
      chk("drop frames on wire", nruns - s_run, 1);
      check_frame("after drop", s_run, s_nib, 60, 0);
      chk("drop data pops", n_dr - s_dr, 1660);
      chk("drop ptr pops", n_pr - s_pr, 3);
      chk("drop drop cnt", tx_drop_cnt, 2);
      chk("drop frame cnt", tx_frame_cnt, 1);
      // asynchronous reset at nibble 50 (byte 17 low nibble) with another descriptor pending
      push_frame(60, 4);
      push_frame(60, 1);
      busy = 0;
      for (int c = 0; c < 200 && !MII_TX_EN; c++) tick;
      chk("abort frame started", MII_TX_EN, 1);
      repeat (50) tick;
      chk("abort pre data_rd", data_fifo_rd, 1);
      #5 rst = 1'b1;
      #1;
      chk("abort tx_en", MII_TX_EN, 0);
      chk("abort txd", MII_TXD, 0);
      chk("abort ptr_rd", ptr_fifo_rd, 0);
      chk("abort data_rd", data_fifo_rd, 0);
      chk("abort frame cnt", tx_frame_cnt, 0);
      chk("abort drop cnt", tx_drop_cnt, 0);
      repeat (3) tick;
      rst = 1'b0;
      for (int c = 0; c < 40; c++) begin
         tick;
         if (ptr_fifo_rd || MII_TX_EN) busy++;
      end
      chk("post-reset idle", busy, 0);
      s_run = nruns; s_nib = nn;
      push_frame(60, 4);
      wait_runs("post-reset", s_run + 1, 1000);
      repeat (30) tick;
      check_frame("post-reset", s_run, s_nib, 60, 4);
      chk("post-reset frame cnt", tx_frame_cnt, 1);
      // CRC unit over "123456789"
      s = "123456789";
      cu_in = 32'hFFFFFFFF;
      for (int i = 0; i < 9; i++) begin
         cu_d = s[i];
         #1;
         cu_in = cu_out;
      end
      chk("crc32 check value", ~cu_in, 32'hCBF43926);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
